cordic_atan2_iter: RTL and testbench



---
 rtl/cordic_atan2_iter.sv | 143 ++++++++++++++
 tb/tb_cordic_atan2_iter.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/cordic_atan2_iter.sv
// cordic_atan2_iter: iterative vectoring CORDIC giving atan2(y, x) in degrees plus the vector magnitude.
// Optional macro CORDIC_GAIN_COMP_EN adds a COMP state that removes the CORDIC gain from mag_out.
module cordic_atan2_iter #(
    parameter int WIDTH = 20,
    parameter int FRAC  = 4,
    parameter int ITER  = 16,
    parameter int GUARD = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [WIDTH-1:0] x_in,
    input  logic signed [WIDTH-1:0] y_in,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [WIDTH-1:0] angle_out,
    output logic signed [WIDTH+1:0] mag_out
);
    localparam int XW  = WIDTH + 2 + GUARD;
    localparam int ZW  = WIDTH + GUARD;
    localparam int AF  = FRAC + GUARD;
    localparam int SHL = (AF > 16) ? AF - 16 : 0;
    localparam int SHR = (AF < 16) ? 16 - AF : 0;
    localparam logic [3:0] LAST = 4'(ITER - 1);
    localparam logic signed [ZW-1:0] Z180 = ZW'(180 * (2 ** AF));
    // atan(2^-i) in degrees, 16 fractional bits
    localparam logic [31:0] ATAN_Q16 [16] = '{
        32'd2949120, 32'd1740967, 32'd919880, 32'd466945,
        32'd234379,  32'd117304,  32'd58666,  32'd29335,
        32'd14668,   32'd7334,    32'd3667,   32'd1833,
        32'd917,     32'd458,     32'd229,    32'd115
    };

    typedef enum logic [1:0] {S_IDLE, S_ITER, S_COMP, S_DONE} state_t;
`ifdef CORDIC_GAIN_COMP_EN
    localparam state_t S_POST = S_COMP;
`else
    localparam state_t S_POST = S_DONE;
`endif

    state_t                  state_q;
    logic [3:0]              cnt_q;
    logic                    zero_q, in_ready_q, out_valid_q;
    logic signed [XW-1:0]    x_q, y_q, x_d, y_d, x_e, y_e;
    logic signed [ZW-1:0]    z_q, z_d, a_i;
    logic signed [WIDTH-1:0] angle_q, angle_d;
    logic signed [WIDTH+1:0] mag_q, mag_d;
    logic signed [ZW:0]      z_r;
    logic signed [XW:0]      x_r;
    logic                    x_neg, y_neg;
    logic                    unused_bits;

    function automatic logic signed [ZW-1:0] atan_lut(input logic [3:0] i);
        logic [63:0] a;
        a = 64'(ATAN_Q16[i]) << SHL;
        a = (a + ((64'd1 << SHR) >> 1)) >> SHR;
        return ZW'(a);
    endfunction

    always_comb begin
        x_neg   = x_in[WIDTH-1];
        x_e     = XW'(x_in) <<< GUARD;
        y_e     = XW'(y_in) <<< GUARD;
        y_neg   = y_q[XW-1];
        a_i     = atan_lut(cnt_q);
        x_d     = y_neg ? x_q - (y_q >>> cnt_q) : x_q + (y_q >>> cnt_q);
        y_d     = y_neg ? y_q + (x_q >>> cnt_q) : y_q - (x_q >>> cnt_q);
        z_d     = y_neg ? z_q - a_i : z_q + a_i;
        z_r     = {z_q[ZW-1], z_q} + (ZW+1)'((2 ** GUARD) / 2);
        x_r     = {x_q[XW-1], x_q} + (XW+1)'((2 ** GUARD) / 2);
        angle_d = zero_q ? '0 : z_r[GUARD +: WIDTH];
        mag_d   = zero_q ? '0 : x_r[GUARD +: WIDTH+2];
    end

`ifdef CORDIC_GAIN_COMP_EN
    logic signed [XW+17:0] prod;
    logic signed [XW-1:0]  x_c;
    // 39797 = 1/K in Q0.16, rounded on the way back down
    always_comb begin
        prod = (XW+18)'(x_q) * (XW+18)'(39797) + (XW+18)'(32768);
        x_c  = XW'(prod >>> 16);
    end
`endif

    assign unused_bits = ^{z_r, x_r};

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            zero_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            x_q         <= '0;
            y_q         <= '0;
            z_q         <= '0;
            angle_q     <= '0;
            mag_q       <= '0;
        end else begin
            case (state_q)
                S_IDLE: if (in_valid) begin
                    x_q        <= x_neg ? -x_e : x_e;
                    y_q        <= x_neg ? -y_e : y_e;
                    z_q        <= !x_neg ? '0 : (y_in[WIDTH-1] ? -Z180 : Z180);
                    zero_q     <= (x_in == '0) && (y_in == '0);
                    cnt_q      <= '0;
                    in_ready_q <= 1'b0;
                    state_q    <= S_ITER;
                end
                S_ITER: begin
                    x_q     <= x_d;
                    y_q     <= y_d;
                    z_q     <= z_d;
                    cnt_q   <= cnt_q + 4'd1;
                    state_q <= (cnt_q == LAST) ? S_POST : S_ITER;
                end
`ifdef CORDIC_GAIN_COMP_EN
                S_COMP: begin
                    x_q     <= x_c;
                    state_q <= S_DONE;
                end
`endif
                // first DONE cycle registers the rounded result; later cycles wait for the consumer
                S_DONE: if (!out_valid_q) begin
                    angle_q     <= angle_d;
                    mag_q       <= mag_d;
                    out_valid_q <= 1'b1;
                end else if (out_ready) begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign angle_out = angle_q;
    assign mag_out   = mag_q;
endmodule

// File: tb/tb_cordic_atan2_iter.sv
// tb_cordic_atan2_iter: table-driven angle/magnitude vectors plus handshake, backpressure and reset sequences.
module tb_cordic_atan2_iter;
    localparam int ITER = 16;
`ifdef CORDIC_GAIN_COMP_EN
    localparam int     LAT    = ITER + 2;
    localparam longint M45_LO = 22;
    localparam longint M45_HI = 23;
    localparam longint MBIG   = 524288;
`else
    localparam int     LAT    = ITER + 1;
    localparam longint M45_LO = 36;
    localparam longint M45_HI = 38;
    localparam longint MBIG   = 863377;
`endif

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               in_valid = 1'b0;
    logic               out_ready = 1'b0;
    logic signed [19:0] x_in = '0;
    logic signed [19:0] y_in = '0;
    logic               in_ready, out_valid;
    logic signed [19:0] angle_out;
    logic signed [21:0] mag_out;
    int                 total = 0;
    int                 bad = 0;

    typedef struct { int x; int y; int ang; } vec_t;
    vec_t vecs[$];

    cordic_atan2_iter #(.WIDTH(20), .FRAC(4), .ITER(ITER), .GUARD(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .x_in(x_in), .y_in(y_in), .out_valid(out_valid), .out_ready(out_ready),
        .angle_out(angle_out), .mag_out(mag_out)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input longint act, input longint lo, input longint hi);
        total++;
        if (act < lo || act > hi) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic run_op(input int x, input int y, output longint ang, output longint mag);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        x_in = 20'(x);
        y_in = 20'(y);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 100) begin
            tick();
            n++;
        end
        check($sformatf("latency(%0d,%0d)", x, y), n, LAT, LAT);
        ang = angle_out;
        mag = mag_out;
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        longint a, m, a0, m0;
        real r;
        int e;
        vecs.push_back(vec_t'{16, 16, 720});
        vecs.push_back(vec_t'{16, 0, 0});
        vecs.push_back(vec_t'{16, 32, 1015});
        vecs.push_back(vec_t'{16, 48, 1145});
        vecs.push_back(vec_t'{16, 80, 1259});
        vecs.push_back(vec_t'{16, 160, 1349});
        vecs.push_back(vec_t'{16, 480, 1409});
        vecs.push_back(vec_t'{16, -16, -720});
        vecs.push_back(vec_t'{16, -32, -1015});
        vecs.push_back(vec_t'{16, -160, -1349});
        vecs.push_back(vec_t'{16, -480, -1409});
        vecs.push_back(vec_t'{16, 8, 425});
        vecs.push_back(vec_t'{32, -16, -425});
        vecs.push_back(vec_t'{-16, 16, 2160});
        vecs.push_back(vec_t'{-16, -16, -2160});
        vecs.push_back(vec_t'{-16, 0, 2880});
        vecs.push_back(vec_t'{0, 16, 1440});
        vecs.push_back(vec_t'{0, -16, -1440});
        vecs.push_back(vec_t'{-524288, 0, 2880});

        repeat (2) tick();
        check("reset in_ready", in_ready, 1, 1);
        check("reset out_valid", out_valid, 0, 0);
        check("reset angle", angle_out, 0, 0);
        check("reset mag", mag_out, 0, 0);
        rst = 1'b1;
        tick();

        run_op(16, 16, a, m);
        check("angle45", a, 718, 722);
        check("mag45", m, M45_LO, M45_HI);
        release_out();

        foreach (vecs[i]) begin
            run_op(vecs[i].x, vecs[i].y, a, m);
            check($sformatf("angle(%0d,%0d)", vecs[i].x, vecs[i].y), a, vecs[i].ang - 2, vecs[i].ang + 2);
            release_out();
        end

        run_op(0, 0, a, m);
        check("zero angle", a, 0, 0);
        check("zero mag", m, 0, 0);
        release_out();

        run_op(-524288, 0, a, m);
        check("big mag", m, MBIG - 64, MBIG + 64);
        release_out();

        for (int k = -30; k <= 30; k++) begin
            r = 16.0 * $atan(real'(k)) * 180.0 / 3.141592653589793;
            e = $rtoi(r + ((r >= 0.0) ? 0.5 : -0.5));
            run_op(16, 16 * k, a, m);
            check($sformatf("sweep y=%0d", k), a, e - 2, e + 2);
            release_out();
        end

        run_op(16, 16, a0, m0);
        check("bp angle", a0, 718, 722);
        x_in = -16;
        y_in = 80;
        in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            check("bp out_valid", out_valid, 1, 1);
            check("bp in_ready", in_ready, 0, 0);
            check("bp angle hold", angle_out, a0, a0);
            check("bp mag hold", mag_out, m0, m0);
        end
        in_valid = 1'b0;
        release_out();
        check("rel out_valid", out_valid, 0, 0);
        check("rel in_ready", in_ready, 1, 1);

        x_in = -16;
        y_in = 16;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (5) tick();
        rst = 1'b0;
        tick();
        check("midrst out_valid", out_valid, 0, 0);
        check("midrst angle", angle_out, 0, 0);
        check("midrst mag", mag_out, 0, 0);
        check("midrst in_ready", in_ready, 1, 1);
        rst = 1'b1;
        run_op(16, 16, a, m);
        check("post-reset angle", a, 718, 722);
        release_out();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
